// File: rtl/creg_arb_pkg.sv
// Shared definitions for the creg_arb locked round-robin register arbiter.
package creg_arb_pkg;
  localparam int NREQ   = 4;
  localparam int IDX_W  = 2;
  localparam int LCNT_W = 8;

  typedef enum logic {OPEN, LOCKED} arb_state_t;
endpackage

// File: rtl/creg_arb_rr_pick4.sv
// rr_pick4: combinational rotating-priority picker, one-hot grant to the
// first requester at or after ptr, searching mod 4.
module rr_pick4
  import creg_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt
);

  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/creg_arb.sv
// creg_arb: four-requester shared register with round-robin arbitration and
// bounded lock ownership. Define CREG_ARB_BYPASS_EN to forward Q_NEXT onto Q_OUT.
module creg_arb
  import creg_arb_pkg::*;
#(
  parameter int               width   = 1,
  parameter logic [width-1:0] init    = '0,
  parameter int               maxlock = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_0,
  input  logic             REQ_1,
  input  logic             REQ_2,
  input  logic             REQ_3,
  input  logic             LOCK_0,
  input  logic             LOCK_1,
  input  logic             LOCK_2,
  input  logic             LOCK_3,
  input  logic [width-1:0] D_IN_0,
  input  logic [width-1:0] D_IN_1,
  input  logic [width-1:0] D_IN_2,
  input  logic [width-1:0] D_IN_3,
  output logic             GNT_0,
  output logic             GNT_1,
  output logic             GNT_2,
  output logic             GNT_3,
  output logic [width-1:0] Q_OUT,
  output logic [width-1:0] Q_NEXT,
  output logic [1:0]       OWNER,
  output logic             LOCKED
);

  logic [NREQ-1:0]   req_v;
  logic [NREQ-1:0]   lock_v;
  logic [NREQ-1:0]   pick_gnt;
  logic [NREQ-1:0]   gnt_v;
  logic [width-1:0]  d_v [NREQ];

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  logic [width-1:0]  q_reg, q_nxt;

  assign req_v  = {REQ_3, REQ_2, REQ_1, REQ_0};
  assign lock_v = {LOCK_3, LOCK_2, LOCK_1, LOCK_0};
  assign d_v[0] = D_IN_0;
  assign d_v[1] = D_IN_1;
  assign d_v[2] = D_IN_2;
  assign d_v[3] = D_IN_3;

  rr_pick4 u_pick (
    .req (req_v),
    .ptr (ptr_q),
    .gnt (pick_gnt)
  );

  // The enum member LOCKED is shadowed by the port, so states are scoped.
  always_comb begin
    gnt_v   = '0;
    q_nxt   = q_reg;
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    lcnt_d  = lcnt_q;
    if (!RST) begin
      q_nxt = init;
    end else begin
      case (state_q)
        creg_arb_pkg::OPEN: begin
          gnt_v = pick_gnt;
          for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
              q_nxt = d_v[i];
              if (lock_v[i]) begin
                state_d = creg_arb_pkg::LOCKED;
                owner_d = IDX_W'(i);
                lcnt_d  = LCNT_W'(1);
              end else begin
                ptr_d = IDX_W'(i + 1);
              end
            end
          end
        end
        creg_arb_pkg::LOCKED: begin
          gnt_v[owner_q] = req_v[owner_q];
          if (req_v[owner_q]) begin
            q_nxt = d_v[owner_q];
          end
          // Leave on a dropped request, a released lock, or an exhausted budget.
          if (!req_v[owner_q] || !lock_v[owner_q] || lcnt_q == LCNT_W'(maxlock)) begin
            state_d = creg_arb_pkg::OPEN;
            ptr_d   = owner_q + 2'd1;
            lcnt_d  = '0;
          end else begin
            lcnt_d = lcnt_q + LCNT_W'(1);
          end
        end
        default: begin
          state_d = creg_arb_pkg::OPEN;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= creg_arb_pkg::OPEN;
      ptr_q   <= '0;
      owner_q <= '0;
      lcnt_q  <= '0;
      q_reg   <= init;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      lcnt_q  <= lcnt_d;
      q_reg   <= q_nxt;
    end
  end

  assign GNT_0  = gnt_v[0];
  assign GNT_1  = gnt_v[1];
  assign GNT_2  = gnt_v[2];
  assign GNT_3  = gnt_v[3];
  assign Q_NEXT = q_nxt;
  assign OWNER  = owner_q;
  assign LOCKED = (state_q == creg_arb_pkg::LOCKED);

`ifdef CREG_ARB_BYPASS_EN
  assign Q_OUT = q_nxt;
`else
  assign Q_OUT = q_reg;
`endif

endmodule

// File: tb/tb_creg_arb.sv
// Scoreboard bench for creg_arb (width=4, init=9, maxlock=3); expected register
// values are queued when each cycle is driven and popped on the following cycle.
module tb_creg_arb;

  localparam int         W    = 4;
  localparam logic [3:0] INIT = 4'h9;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [3:0]   lock;
  logic [W-1:0] d [4];
  wire          g0, g1, g2, g3;
  wire  [3:0]   gnt = {g3, g2, g1, g0};
  wire  [W-1:0] q_out, q_next;
  wire  [1:0]   owner;
  wire          locked;

  logic [W-1:0] sb_q [$];
  int           assert_count = 0;
  int           fail_count   = 0;
  bit           pin_d0       = 1'b0;

  always #5 clk = ~clk;

  creg_arb #(.width(W), .init(INIT), .maxlock(3)) dut (
    .CLK    (clk),
    .RST    (rst),
    .REQ_0  (req[0]),
    .REQ_1  (req[1]),
    .REQ_2  (req[2]),
    .REQ_3  (req[3]),
    .LOCK_0 (lock[0]),
    .LOCK_1 (lock[1]),
    .LOCK_2 (lock[2]),
    .LOCK_3 (lock[3]),
    .D_IN_0 (d[0]),
    .D_IN_1 (d[1]),
    .D_IN_2 (d[2]),
    .D_IN_3 (d[3]),
    .GNT_0  (g0),
    .GNT_1  (g1),
    .GNT_2  (g2),
    .GNT_3  (g3),
    .Q_OUT  (q_out),
    .Q_NEXT (q_next),
    .OWNER  (owner),
    .LOCKED (locked)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle at the falling edge, check combinational outputs, then
  // queue the value the register must hold after the next rising edge.
  task automatic applyStimulus(input bit rst_v, input logic [3:0] req_v, input logic [3:0] lock_v,
                               input logic [3:0] exp_gnt, input bit exp_locked,
                               input logic [1:0] exp_owner);
    logic [W-1:0] exp_reg;
    logic [W-1:0] exp_next;
    bit           have_reg;
    @(negedge clk);
    rst  = rst_v;
    req  = req_v;
    lock = lock_v;
    for (int i = 0; i < 4; i++) d[i] = W'($urandom_range(0, 15));
    if (pin_d0) d[0] = 4'h5;
    #1;
    have_reg = (sb_q.size() > 0);
    exp_reg  = have_reg ? sb_q.pop_front() : 'x;
    exp_next = exp_reg;
    for (int i = 0; i < 4; i++) if (exp_gnt[i]) exp_next = d[i];
    if (!rst_v) exp_next = INIT;
    checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
    checkOutput("q_next", 32'(q_next), 32'(exp_next));
    checkOutput("locked", 32'(locked), 32'(exp_locked));
    if (exp_locked) checkOutput("owner", 32'(owner), 32'(exp_owner));
    if (have_reg) begin
`ifdef CREG_ARB_BYPASS_EN
      checkOutput("q_out", 32'(q_out), 32'(exp_next));
`else
      checkOutput("q_out", 32'(q_out), 32'(exp_reg));
`endif
    end
    sb_q.push_back(exp_next);
  endtask

  initial begin
    rst  = 1'b0;
    req  = '0;
    lock = '0;
    for (int i = 0; i < 4; i++) d[i] = '0;

    // Reset ignores requests and locks
    applyStimulus(0, 4'b1111, 4'b1111, 4'b0000, 0, 2'd0);
    applyStimulus(0, 4'b1111, 4'b0000, 4'b0000, 0, 2'd0);

    // Full request load rotates 0,1,2,3,0
    applyStimulus(1, 4'b1111, 4'b0000, 4'b0001, 0, 2'd0);
    applyStimulus(1, 4'b1111, 4'b0000, 4'b0010, 0, 2'd0);
    applyStimulus(1, 4'b1111, 4'b0000, 4'b0100, 0, 2'd0);
    applyStimulus(1, 4'b1111, 4'b0000, 4'b1000, 0, 2'd0);
    applyStimulus(1, 4'b1111, 4'b0000, 4'b0001, 0, 2'd0);

    // Pointer to 3, then wrap to 0
    applyStimulus(1, 4'b0100, 4'b0000, 4'b0100, 0, 2'd0);
    applyStimulus(1, 4'b1001, 4'b0000, 4'b1000, 0, 2'd0);
    applyStimulus(1, 4'b1001, 4'b0000, 4'b0001, 0, 2'd0);

    // Lock on 1 with 2 waiting: one open grant plus three locked grants
    applyStimulus(1, 4'b0110, 4'b0010, 4'b0010, 0, 2'd0);
    applyStimulus(1, 4'b0110, 4'b0010, 4'b0010, 1, 2'd1);
    applyStimulus(1, 4'b0110, 4'b0010, 4'b0010, 1, 2'd1);
    applyStimulus(1, 4'b0110, 4'b0010, 4'b0010, 1, 2'd1);
    applyStimulus(1, 4'b0110, 4'b0010, 4'b0100, 0, 2'd0);

    // Owner 2 drops its request: idle cycle, then pointer 3 picks 0
    applyStimulus(1, 4'b0100, 4'b0100, 4'b0100, 0, 2'd0);
    applyStimulus(1, 4'b0001, 4'b0000, 4'b0000, 1, 2'd2);
    applyStimulus(1, 4'b0001, 4'b0000, 4'b0001, 0, 2'd0);

    // Reset during a lock abandons it and restores init and ptr=0
    applyStimulus(1, 4'b0010, 4'b0010, 4'b0010, 0, 2'd0);
    applyStimulus(0, 4'b0010, 4'b0010, 4'b0000, 1, 2'd1);
    applyStimulus(1, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0);
    applyStimulus(1, 4'b1111, 4'b0000, 4'b0001, 0, 2'd0);

    // Releasing LOCK on a locked grant exits with ptr past the owner
    applyStimulus(1, 4'b1000, 4'b1000, 4'b1000, 0, 2'd0);
    applyStimulus(1, 4'b1001, 4'b0000, 4'b1000, 1, 2'd3);
    applyStimulus(1, 4'b1001, 4'b0000, 4'b0001, 0, 2'd0);

    // Known write value 5 from requester 0, then an idle cycle
    pin_d0 = 1'b1;
    applyStimulus(1, 4'b0001, 4'b0000, 4'b0001, 0, 2'd0);
    pin_d0 = 1'b0;
    applyStimulus(1, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0);
    applyStimulus(1, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
